// File: rtl/dfa_walker_pkg.sv
// Shared widths, entry layout and FSM encoding for the DFA walker.
package dfa_walker_pkg;

    localparam int unsigned N     = 13;
    localparam int unsigned W     = 16;
    localparam int unsigned SYM_W = 4;
    localparam int unsigned ST_W  = N - SYM_W;
    localparam int unsigned TAG_W = 6;
    localparam int unsigned POS_W = 16;
    localparam int unsigned CNT_W = 16;

    localparam logic [ST_W-1:0] DEFAULT_START = ST_W'(0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_UPDATE = 2'd2
    } fsm_t;

    // Transition-table word: [15] accept, [14:9] tag, [8:0] next state
    typedef struct packed {
        logic             acc;
        logic [TAG_W-1:0] tag;
        logic [ST_W-1:0]  next_state;
    } entry_t;

endpackage

// File: rtl/dfa_walker.sv
// Walks a DFA over a symbol stream using an external 1-cycle-read transition BRAM,
// reports accepting transitions, and lets the host load the table while idle.
module dfa_walker
    import dfa_walker_pkg::*;
#(
    parameter logic [ST_W-1:0] START_STATE = DEFAULT_START
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [SYM_W-1:0] s_sym,
    input  logic             s_last,
    input  logic             cfg_we,
    input  logic [N-1:0]     cfg_addr,
    input  logic [W-1:0]     cfg_wdata,
    output logic             cfg_busy,
    output logic [N-1:0]     tbl_addr,
    output logic             tbl_rw,
    output logic [W-1:0]     tbl_wdata,
    input  logic [W-1:0]     tbl_rdata,
    output logic             m_valid,
    output logic [TAG_W-1:0] m_tag,
    output logic [POS_W-1:0] m_pos,
    output logic [ST_W-1:0]  cur_state,
    output logic [CNT_W-1:0] match_cnt
);

    fsm_t             fsm;
    logic             last_q;
    logic [POS_W-1:0] pos;
    entry_t           entry;

    assign entry    = entry_t'(tbl_rdata);
    // Host writes take the shared BRAM port, so a pending write stalls symbol intake
    assign s_ready  = (fsm == S_IDLE) && !cfg_we;
    assign cfg_busy = (fsm != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= S_IDLE;
            last_q    <= 1'b0;
            pos       <= '0;
            cur_state <= START_STATE;
            match_cnt <= '0;
            m_valid   <= 1'b0;
            m_tag     <= '0;
            m_pos     <= '0;
            tbl_addr  <= '0;
            tbl_rw    <= 1'b0;
            tbl_wdata <= '0;
        end else begin
            m_valid <= 1'b0;
            tbl_rw  <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (cfg_we) begin
                        tbl_addr  <= cfg_addr;
                        tbl_wdata <= cfg_wdata;
                        tbl_rw    <= 1'b1;
                    end else if (s_valid) begin
                        last_q   <= s_last;
                        tbl_addr <= {cur_state, s_sym};
                        fsm      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    fsm <= S_UPDATE;
                end
                S_UPDATE: begin
                    cur_state <= last_q ? START_STATE : entry.next_state;
                    pos       <= last_q ? POS_W'(0) : POS_W'(pos + POS_W'(1));
                    if (entry.acc) begin
                        m_valid <= 1'b1;
                        m_tag   <= entry.tag;
                        m_pos   <= pos;
                        if (match_cnt != '1) begin
                            match_cnt <= CNT_W'(match_cnt + CNT_W'(1));
                        end
                    end
                    fsm <= S_IDLE;
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dfa_walker.sv
// Bench for dfa_walker with an 8K x 16 registered-read BRAM model and a symbol-level reference DFA.
module tb_dfa_walker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [3:0]  s_sym = '0;
    logic        s_last = 1'b0;
    logic        cfg_we = 1'b0;
    logic [12:0] cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic        cfg_busy;
    logic [12:0] tbl_addr;
    logic        tbl_rw;
    logic [15:0] tbl_wdata;
    logic [15:0] tbl_rdata;
    logic        m_valid;
    logic [5:0]  m_tag;
    logic [15:0] m_pos;
    logic [8:0]  cur_state;
    logic [15:0] match_cnt;

    logic [15:0] mem     [0:8191];
    logic [15:0] ref_tbl [0:8191];
    logic [8:0]  ref_state;
    logic [15:0] ref_pos;
    logic [15:0] ref_cnt;

    typedef struct {
        logic [5:0]  tag;
        logic [15:0] pos;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dfa_walker dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_sym(s_sym), .s_last(s_last),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_busy(cfg_busy),
        .tbl_addr(tbl_addr), .tbl_rw(tbl_rw), .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata),
        .m_valid(m_valid), .m_tag(m_tag), .m_pos(m_pos),
        .cur_state(cur_state), .match_cnt(match_cnt)
    );

    // Single-port BRAM: registered read, write when rw=1
    always @(posedge clk) begin
        if (tbl_rw) mem[tbl_addr] <= tbl_wdata;
        tbl_rdata <= mem[tbl_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [15:0] mk(input logic acc, input logic [5:0] tag, input logic [8:0] ns);
        return {acc, tag, ns};
    endfunction

    // Reference DFA step at symbol granularity
    task automatic model(input logic [3:0] sym, input logic last);
        logic [12:0] idx;
        logic [15:0] e;
        idx = {ref_state, sym};
        e = ref_tbl[idx];
        if (e[15]) begin
            exp_q.push_back('{tag: e[14:9], pos: ref_pos});
            if (ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
        end
        ref_state = last ? 9'd0 : e[8:0];
        ref_pos   = last ? 16'd0 : ref_pos + 16'd1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (cfg_busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (cfg_busy) timeout("wait_idle");
    endtask

    task automatic cfg_write(input logic [12:0] addr, input logic [15:0] data);
        wait_idle();
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        @(posedge clk); #1;
        chk("cfg_rw_set", 32'(tbl_rw), 32'd1);
        chk("cfg_addr", 32'(tbl_addr), 32'(addr));
        ref_tbl[addr] = data;
        @(negedge clk);
        cfg_we = 1'b0;
        @(posedge clk); #1;
        chk("cfg_rw_one_cycle", 32'(tbl_rw), 32'd0);
        @(negedge clk);
    endtask

    task automatic send_sym(input logic [3:0] sym, input logic last);
        int k = 0;
        wait_idle();
        s_valid = 1'b1; s_sym = sym; s_last = last;
        #1;
        while (!s_ready && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        if (!s_ready) begin
            timeout("s_ready");
            s_valid = 1'b0;
            return;
        end
        model(sym, last);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        wait_idle();
        chk("cur_state", 32'(cur_state), 32'(ref_state));
        chk("match_cnt", 32'(match_cnt), 32'(ref_cnt));
    endtask

    // Scoreboard monitor: every match pulse must correspond to a predicted match
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && m_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_match: tag %0h pos %0h with nothing expected", m_tag, m_pos);
            end else begin
                e = exp_q.pop_front();
                chk("m_tag", 32'(m_tag), 32'(e.tag));
                chk("m_pos", 32'(m_pos), 32'(e.pos));
            end
        end
    end

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i] = 16'h0000;
            ref_tbl[i] = 16'h0000;
        end
        ref_state = '0; ref_pos = '0; ref_cnt = '0;

        repeat (3) @(negedge clk);
        chk("rst_cur_state", 32'(cur_state), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_match_cnt", 32'(match_cnt), 32'd0);
        chk("rst_tbl_rw", 32'(tbl_rw), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Load then walk: 0x8A05 = accept, tag 5, next 5
        cfg_write(13'h001, 16'h8A05);
        send_sym(4'd1, 1'b0);
        chk("load_state", 32'(cur_state), 32'd5);
        @(negedge clk);
        chk("m_tag_hold", 32'(m_tag), 32'd5);
        chk("m_valid_pulse", 32'(m_valid), 32'd0);

        // Frame positions restart after s_last
        send_sym(4'd0, 1'b1);
        cfg_write(13'h003, mk(1'b1, 6'd1, 9'd7));
        cfg_write(13'h072, mk(1'b1, 6'd2, 9'd8));
        cfg_write(13'h081, mk(1'b1, 6'd3, 9'd9));
        send_sym(4'd3, 1'b0);
        send_sym(4'd2, 1'b0);
        send_sym(4'd1, 1'b1);
        chk("frame_end_state", 32'(cur_state), 32'd0);
        send_sym(4'd3, 1'b0);

        // Contention: cfg wins, symbol follows; cfg during LOOKUP dropped
        wait_idle();
        cfg_we = 1'b1; cfg_addr = 13'h0A0; cfg_wdata = mk(1'b1, 6'd9, 9'd3);
        s_valid = 1'b1; s_sym = 4'd2; s_last = 1'b0;
        #1;
        chk("contention_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        chk("contention_rw", 32'(tbl_rw), 32'd1);
        chk("contention_idle", 32'(cfg_busy), 32'd0);
        ref_tbl[13'h0A0] = cfg_wdata;
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        chk("contention_ready_next", 32'(s_ready), 32'd1);
        model(4'd2, 1'b0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("lookup_busy", 32'(cfg_busy), 32'd1);
        cfg_we = 1'b1; cfg_addr = 13'h0B0; cfg_wdata = 16'hFFFF;
        @(posedge clk); #1;
        chk("cfg_dropped_rw", 32'(tbl_rw), 32'd0);
        cfg_we = 1'b0;
        @(negedge clk);
        wait_idle();
        chk("contention_state", 32'(cur_state), 32'(ref_state));
        @(negedge clk);
        chk("cfg_dropped_mem", 32'(mem[13'h0B0]), 32'(ref_tbl[13'h0B0]));

        // Randomized mix of table loads and symbols over a small state space
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg_write({9'($urandom_range(0, 15)), 4'($urandom)},
                          mk(1'($urandom), 6'($urandom), 9'($urandom_range(0, 15))));
            end else begin
                send_sym(4'($urandom), $urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end

        // Reset while the lookup is in flight
        send_sym(4'd0, 1'b1);
        cfg_write(13'h001, 16'h8A05);
        wait_idle();
        s_valid = 1'b1; s_sym = 4'd1; s_last = 1'b0;
        #1;
        chk("rst_lookup_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("rst_lookup_busy", 32'(cfg_busy), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_state", 32'(cur_state), 32'd0);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_match_cnt", 32'(match_cnt), 32'd0);
        rst_n = 1'b1;
        ref_state = '0; ref_pos = '0; ref_cnt = '0;
        repeat (4) @(negedge clk);
        chk("midrst_no_match", 32'(m_valid), 32'd0);
        chk("midrst_tbl_kept", 32'(mem[13'h001]), 32'h8A05);

        // Saturation: preload the counter near the top, then keep matching
        @(negedge clk);
        force dut.match_cnt = 16'hFFFD;
        #1;
        release dut.match_cnt;
        ref_cnt = 16'hFFFD;
        for (int i = 0; i < 4; i++) send_sym(4'd1, 1'b1);
        chk("sat_value", 32'(match_cnt), 32'hFFFF);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
